// File: rtl/alu_control_seq_if.sv
// rtl/alu_control_seq_if.sv - MDU handshake bundle between the ALU control sequencer and the multiply/divide unit
//
// Signals:
//   md_start      sequencer -> MDU   one-cycle start pulse
//   md_op         sequencer -> MDU   latched funct3 of the M-op
//   md_done       MDU -> sequencer   result ready (divide/remainder ops)
//   result_valid  sequencer -> WB    one-cycle pulse, MDU result may be written back
//   md_timeout    sequencer -> WB    one-cycle pulse with result_valid when a divide timed out
// Modports: master = sequencer side, slave = MDU / write-back side.
interface alu_control_seq_if;
    logic       md_start;
    logic [2:0] md_op;
    logic       md_done;
    logic       result_valid;
    logic       md_timeout;

    modport master (
        output md_start,
        output md_op,
        output result_valid,
        output md_timeout,
        input  md_done
    );

    modport slave (
        input  md_start,
        input  md_op,
        input  result_valid,
        input  md_timeout,
        output md_done
    );
endinterface

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - RV32I/M ALU control decoder with multi-cycle MDU sequencer
//
// Decodes R-type and I-type ALU operations into a 4-bit ALUSel and sequences
// RV32M operations through an external multiply/divide unit.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   instr_valid    Instruction/ALUOp valid this cycle
//   Instruction    instruction word (uses [31:25], [14:12], [30])
//   ALUOp          00 add, 01 sub, 10 R-type, 11 I-type
//   flush          abort any in-flight M-op
//   ALUSel         ALU operation select (combinational)
//   stall          hold pipeline (combinational)
//   illegal        unsupported R-type encoding (combinational)
//   md             MDU handshake (md_start, md_op, md_done, result_valid, md_timeout)
module alu_control_seq #(
    parameter int N           = 32,
    parameter int MUL_LAT     = 3,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    input  logic [N-1:0]              Instruction,
    input  logic [1:0]                ALUOp,
    input  logic                      flush,
    output logic [3:0]                ALUSel,
    output logic                      stall,
    output logic                      illegal,
    alu_control_seq_if.master         md
);

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b1001;
    localparam logic [3:0] SEL_MDU  = 4'b1010;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

    // Only funct7 and funct3 take part in decoding; the rest is folded away.
    localparam logic [N-1:0] USED_MASK = N'(32'hFE00_7000);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             timeout_nx;

    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       bit30;
    logic       is_mop;
    logic       unused_bits;

    assign funct7      = Instruction[31:25];
    assign funct3      = Instruction[14:12];
    assign bit30       = Instruction[30];
    assign unused_bits = ^(Instruction & ~USED_MASK);

    assign is_mop = instr_valid && (ALUOp == 2'b10) && (funct7 == 7'b0000001);

    function automatic logic [3:0] base_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  base_sel = SEL_ADD;
            3'b001:  base_sel = SEL_SLL;
            3'b010:  base_sel = SEL_SLT;
            3'b011:  base_sel = SEL_SLTU;
            3'b100:  base_sel = SEL_XOR;
            3'b101:  base_sel = SEL_SRL;
            3'b110:  base_sel = SEL_OR;
            default: base_sel = SEL_AND;
        endcase
    endfunction

    always_comb begin
        ALUSel  = SEL_AND;
        illegal = 1'b0;
        case (ALUOp)
            2'b00: ALUSel = SEL_ADD;
            2'b01: ALUSel = SEL_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    ALUSel = base_sel(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    ALUSel = SEL_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    ALUSel = SEL_SRA;
                end else if (funct7 == 7'b0000001) begin
                    ALUSel = SEL_MDU;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                // I-type: bit 30 is part of the immediate except for shifts-right.
                if (funct3 == 3'b101 && bit30) begin
                    ALUSel = SEL_SRA;
                end else begin
                    ALUSel = base_sel(funct3);
                end
            end
        endcase
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mop) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                state_nx = S_WAIT;
                cnt_nx   = md.md_op[2] ? '0 : MUL_LAST;
            end
            S_WAIT: begin
                if (!md.md_op[2]) begin
                    if (cnt == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end else if (md.md_done) begin
                    state_nx = S_DONE;
                end else if (cnt == DIV_LAST) begin
                    state_nx   = S_DONE;
                    timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Flush beats everything, including a completing md_done.
        if (flush) begin
            state_nx   = S_IDLE;
            cnt_nx     = '0;
            timeout_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            md.md_start     <= 1'b0;
            md.md_op        <= 3'b000;
            md.result_valid <= 1'b0;
            md.md_timeout   <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            md.md_start     <= (state_nx == S_START);
            md.result_valid <= (state_nx == S_DONE);
            md.md_timeout   <= timeout_nx;
            if (state == S_IDLE && state_nx == S_START) begin
                md.md_op <= funct3;
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            stall = (state == S_START) || (state == S_WAIT) ||
                    ((state == S_IDLE) && is_mop);
        end
    end

endmodule
